// File: rtl/trackball_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trackball_pkg
//  Purpose  : Shared constants and helpers for the trackball step generator:
//             output-mode codes, quadrature phase sequencing and the
//             symmetric saturating adder used by every axis accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
package trackball_pkg;

    localparam int MODE_DIRCLK = 0;   // bit1 = direction, bit0 = toggling clock
    localparam int MODE_QUAD   = 1;   // bit1 = A, bit0 = B (Gray sequence)

    // Forward (dir=1): 00 -> 01 -> 11 -> 10 -> 00. Reverse walks it backwards.
    function automatic logic [1:0] gray_next(input logic [1:0] p, input logic dir);
        logic [1:0] n;
        case (p)
            2'b00:   n = dir ? 2'b01 : 2'b10;
            2'b01:   n = dir ? 2'b11 : 2'b00;
            2'b11:   n = dir ? 2'b10 : 2'b01;
            default: n = dir ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

    // a + b clamped to +/-(2^(width-1)-1). The sum is formed one bit wider
    // than the operands so it can never wrap before it is clamped. The range
    // is symmetric, so the most-negative code of a width-bit word is never
    // produced.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int width);
        logic signed [32:0] sum;
        logic signed [32:0] lim;
        logic signed [32:0] res;
        sum = 33'(a) + 33'(b);
        lim = (33'sd1 <<< (width - 1)) - 33'sd1;
        if (sum > lim)
            res = lim;
        else if (sum < -lim)
            res = -lim;
        else
            res = sum;
        return res[31:0];
    endfunction

endpackage : trackball_pkg
`default_nettype wire

// File: rtl/trackball_axis.sv
`default_nettype none
// ============================================================================
//  Module   : trackball_axis
//  Purpose  : One axis of the trackball step generator: a saturating signed
//             accumulator drained one count per step tick, plus the output
//             encoder (dir/clock or Gray quadrature).
//  Ports    : clk_sys  - system clock
//             reset_n  - synchronous active-low reset
//             tick     - shared step tick from the prescaler
//             in_valid - d_i carries a new scaled delta this cycle
//             d_i      - scaled, optionally inverted, signed delta
//             step_o   - encoded 2-bit output
//             busy_o   - accumulator nonzero (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int MODE  = MODE_DIRCLK,
    parameter int DW    = 13
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] d_i,
    output logic [1:0]           step_o,
    output logic                 busy_o
);

    logic signed [ACC_W-1:0] r_acc;
    logic [1:0]              r_code;
    logic                    r_busy;

    logic                    w_neg;
    logic                    w_step;
    logic                    w_up;
    logic signed [31:0]      w_base;
    logic signed [31:0]      w_add;
    logic signed [ACC_W-1:0] w_acc_next;

    // The step decision uses the sign of the accumulator as it stands at the
    // start of the cycle; a simultaneous delta only affects later steps.
    assign w_neg  = r_acc[ACC_W-1];
    assign w_step = tick && (r_acc != '0);
    assign w_up   = ~w_neg;

    always_comb begin
        w_base = 32'(r_acc);
        if (w_step)
            w_base = w_neg ? (w_base + 32'sd1) : (w_base - 32'sd1);
        w_add      = in_valid ? 32'(d_i) : 32'sd0;
        w_acc_next = ACC_W'(sat_add(w_base, w_add, ACC_W));
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_acc  <= w_acc_next;
            r_busy <= (w_acc_next != '0);
        end
    end

    generate
        if (MODE == MODE_QUAD) begin : g_quad
            always_ff @(posedge clk_sys) begin
                if (!reset_n)
                    r_code <= 2'b00;
                else if (w_step)
                    r_code <= gray_next(r_code, w_up);
            end
        end else begin : g_dirclk
            // Direction bit is only rewritten on a step, so it persists idle.
            always_ff @(posedge clk_sys) begin
                if (!reset_n)
                    r_code <= 2'b00;
                else if (w_step)
                    r_code <= {w_up, ~r_code[0]};
            end
        end
    endgenerate

    assign step_o = r_code;
    assign busy_o = r_busy;

endmodule : trackball_axis
`default_nettype wire

// File: rtl/trackball_quad.sv
`default_nettype none
// ============================================================================
//  Module   : trackball_quad
//  Purpose  : Converts per-axis mouse motion deltas into arcade trackball /
//             spinner step outputs. Owns the shared step prescaler and the
//             delta unpacking/scaling; one trackball_axis per axis.
//  Ports    : clk_sys  - system clock
//             reset_n  - synchronous active-low reset
//             in_valid - one-cycle strobe, delta_i holds a new sample
//             delta_i  - AXES x 9-bit two's-complement deltas, axis k at [9k+8:9k]
//             invert_i - per-axis direction inversion, used with in_valid
//             enable_i - 0 pauses stepping; accumulation continues
//             step_o   - AXES x 2-bit encoded output, axis k at [2k+1:2k]
//             busy_o   - per-axis accumulator nonzero
//  Revision : 1.0 - initial release
// ============================================================================
module trackball_quad
    import trackball_pkg::*;
#(
    parameter int AXES       = 2,
    parameter int ACC_W      = 12,
    parameter int STEP_DIV   = 1,
    parameter int SENS_SHIFT = 0,
    parameter int MODE       = MODE_DIRCLK
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [AXES*9-1:0]   delta_i,
    input  logic [AXES-1:0]     invert_i,
    input  logic                enable_i,
    output logic [AXES*2-1:0]   step_o,
    output logic [AXES-1:0]     busy_o
);

    localparam int c_PW = $clog2(STEP_DIV + 1);
    // 9-bit delta, up to 3 bits of shift, plus one bit so that negating the
    // most-negative shifted delta cannot wrap.
    localparam int c_DW = 13;

    logic [c_PW-1:0] r_presc;
    logic            w_tick;

    assign w_tick = enable_i && (r_presc == c_PW'(STEP_DIV - 1));

    // Holds its value while paused so the step cadence resumes where it left.
    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            r_presc <= '0;
        else if (enable_i)
            r_presc <= w_tick ? '0 : (r_presc + c_PW'(1));
    end

    generate
        for (genvar k = 0; k < AXES; k++) begin : g_axis
            logic signed [8:0]      w_raw;
            logic signed [c_DW-1:0] w_sh;
            logic signed [c_DW-1:0] w_d;

            assign w_raw = delta_i[9*k +: 9];
            assign w_sh  = c_DW'(w_raw) <<< SENS_SHIFT;
            assign w_d   = invert_i[k] ? -w_sh : w_sh;

            trackball_axis #(
                .ACC_W (ACC_W),
                .MODE  (MODE),
                .DW    (c_DW)
            ) u_axis (
                .clk_sys  (clk_sys),
                .reset_n  (reset_n),
                .tick     (w_tick),
                .in_valid (in_valid),
                .d_i      (w_d),
                .step_o   (step_o[2*k +: 2]),
                .busy_o   (busy_o[k])
            );
        end
    endgenerate

endmodule : trackball_quad
`default_nettype wire

// File: tb/tb_trackball_quad.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trackball_quad
//  Purpose  : Self-checking bench for trackball_quad. Four instances cover
//             dir/clock, quadrature, saturation and prescaler/invert setups.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trackball_quad;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    // dut0: 2 axes, dir/clock, STEP_DIV=1
    logic        v0 = 1'b0;
    logic [17:0] d0 = '0;
    logic [1:0]  i0 = '0;
    logic        e0 = 1'b1;
    logic [3:0]  s0;
    logic [1:0]  b0;

    // dut1: 2 axes, quadrature
    logic        v1 = 1'b0;
    logic [17:0] d1 = '0;
    logic [1:0]  i1 = '0;
    logic        e1 = 1'b1;
    logic [3:0]  s1;
    logic [1:0]  b1;

    // dut2: 1 axis, ACC_W=10 saturation
    logic        v2 = 1'b0;
    logic [8:0]  d2 = '0;
    logic [0:0]  i2 = '0;
    logic        e2 = 1'b1;
    logic [1:0]  s2;
    logic [0:0]  b2;

    // dut3: 1 axis, STEP_DIV=4
    logic        v3 = 1'b0;
    logic [8:0]  d3 = '0;
    logic [0:0]  i3 = '0;
    logic        e3 = 1'b1;
    logic [1:0]  s3;
    logic [0:0]  b3;

    trackball_quad #(.AXES(2), .ACC_W(12), .STEP_DIV(1), .SENS_SHIFT(0), .MODE(0)) dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .in_valid(v0), .delta_i(d0),
        .invert_i(i0), .enable_i(e0), .step_o(s0), .busy_o(b0));

    trackball_quad #(.AXES(2), .ACC_W(12), .STEP_DIV(1), .SENS_SHIFT(0), .MODE(1)) dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .in_valid(v1), .delta_i(d1),
        .invert_i(i1), .enable_i(e1), .step_o(s1), .busy_o(b1));

    trackball_quad #(.AXES(1), .ACC_W(10), .STEP_DIV(1), .SENS_SHIFT(0), .MODE(0)) dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .in_valid(v2), .delta_i(d2),
        .invert_i(i2), .enable_i(e2), .step_o(s2), .busy_o(b2));

    trackball_quad #(.AXES(1), .ACC_W(12), .STEP_DIV(4), .SENS_SHIFT(0), .MODE(0)) dut3 (
        .clk_sys(clk_sys), .reset_n(reset_n), .in_valid(v3), .delta_i(d3),
        .invert_i(i3), .enable_i(e3), .step_o(s3), .busy_o(b3));

    typedef struct {
        logic       valid;
        logic [8:0] dl1;
        logic [8:0] dl0;
        logic [1:0] inv;
        logic       en;
        logic [3:0] exp_step;
        logic [1:0] exp_busy;
    } vec_t;

    vec_t vecs[22];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // Cycle-by-cycle vectors for dut0; expected values are after the edge.
        vecs[0]  = '{1'b1, 9'h000, 9'h005, 2'b00, 1'b1, 4'b0000, 2'b01};
        vecs[1]  = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0011, 2'b01};
        vecs[2]  = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0010, 2'b01};
        vecs[3]  = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0011, 2'b01};
        vecs[4]  = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0010, 2'b01};
        vecs[5]  = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0011, 2'b00};
        vecs[6]  = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0011, 2'b00};
        vecs[7]  = '{1'b1, 9'h1FE, 9'h000, 2'b00, 1'b1, 4'b0011, 2'b10};
        vecs[8]  = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0111, 2'b10};
        vecs[9]  = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0011, 2'b00};
        vecs[10] = '{1'b1, 9'h000, 9'h001, 2'b01, 1'b1, 4'b0011, 2'b01};
        vecs[11] = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0000, 2'b00};
        vecs[12] = '{1'b1, 9'h000, 9'h002, 2'b00, 1'b0, 4'b0000, 2'b01};
        vecs[13] = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b0, 4'b0000, 2'b01};
        vecs[14] = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0011, 2'b01};
        vecs[15] = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0010, 2'b00};
        vecs[16] = '{1'b1, 9'h000, 9'h002, 2'b00, 1'b1, 4'b0010, 2'b01};
        // acc=+2 steps up while -4 arrives: acc becomes -3
        vecs[17] = '{1'b1, 9'h000, 9'h1FC, 2'b00, 1'b1, 4'b0011, 2'b01};
        vecs[18] = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0000, 2'b01};
        vecs[19] = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0001, 2'b01};
        vecs[20] = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0000, 2'b00};
        vecs[21] = '{1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 4'b0000, 2'b00};

        // ---------------- reset / idle ----------------
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_step0", 32'(s0), 32'h0);
        chk("rst_busy0", 32'(b0), 32'h0);
        chk("rst_step1", 32'(s1), 32'h0);
        chk("rst_busy2", 32'(b2), 32'h0);
        reset_n = 1'b1;
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (s0 !== 4'b0 || b0 !== 2'b0) bad++;
            end
            chk("idle_100", 32'(bad), 32'h0);
        end

        // ---------------- table-driven: dut0 ----------------
        for (int n = 0; n < 22; n++) begin
            v0 = vecs[n].valid;
            d0 = {vecs[n].dl1, vecs[n].dl0};
            i0 = vecs[n].inv;
            e0 = vecs[n].en;
            tick();
            chk($sformatf("vec%0d_step", n), 32'(s0), 32'(vecs[n].exp_step));
            chk($sformatf("vec%0d_busy", n), 32'(b0), 32'(vecs[n].exp_busy));
        end
        v0 = 1'b0; d0 = '0; i0 = '0; e0 = 1'b1;

        // ---------------- quadrature negative: dut1 axis1 ----------------
        begin
            logic [1:0] exp_q[5];
            exp_q[0] = 2'b10; exp_q[1] = 2'b11; exp_q[2] = 2'b01;
            exp_q[3] = 2'b01; exp_q[4] = 2'b01;
            v1 = 1'b1;
            d1 = {9'h1FD, 9'h000};
            tick();
            v1 = 1'b0; d1 = '0;
            chk("quad_load", 32'(s1[3:2]), 32'h0);
            chk("quad_busy", 32'(b1), 32'h2);
            for (int n = 0; n < 5; n++) begin
                tick();
                chk($sformatf("quad_ph%0d", n), 32'(s1[3:2]), 32'(exp_q[n]));
            end
            chk("quad_ax0", 32'(s1[1:0]), 32'h0);
            chk("quad_idle", 32'(b1), 32'h0);
        end

        // ---------------- saturation: dut2 ----------------
        begin
            int  cnt;
            bit  done;
            logic [1:0] prev;
            e2 = 1'b0;
            for (int n = 0; n < 8; n++) begin
                v2 = 1'b1; d2 = 9'h0FF;
                tick();
            end
            v2 = 1'b0; d2 = '0;
            tick();
            chk("sat_hold_step", 32'(s2), 32'h0);
            chk("sat_hold_busy", 32'(b2), 32'h1);
            e2 = 1'b1;
            cnt = 0; done = 1'b0; prev = s2;
            for (int c = 0; c < 2000 && !done; c++) begin
                tick();
                if (s2[0] !== prev[0]) cnt++;
                prev = s2;
                if (b2 == 1'b0) done = 1'b1;
            end
            chk("sat_drained", 32'(done), 32'h1);
            chk("sat_steps", 32'(cnt), 32'd511);
            chk("sat_dir", 32'(s2[1]), 32'h1);
        end

        // ---------------- prescaler + invert: dut3 ----------------
        begin
            int chg_cyc[$];
            int bad_dir;
            logic [1:0] prev;
            v3 = 1'b1; d3 = 9'h002; i3 = 1'b1;
            tick();
            v3 = 1'b0; d3 = '0; i3 = 1'b0;
            prev = s3; bad_dir = 0;
            for (int c = 0; c < 24; c++) begin
                tick();
                if (s3 !== prev) begin
                    chg_cyc.push_back(c);
                    if (s3[1] !== 1'b0) bad_dir++;
                end
                prev = s3;
            end
            chk("div_nsteps", 32'(chg_cyc.size()), 32'd2);
            chk("div_dir", 32'(bad_dir), 32'h0);
            if (chg_cyc.size() == 2)
                chk("div_spacing", 32'(chg_cyc[1] - chg_cyc[0]), 32'd4);
            else
                chk("div_spacing", 32'hFFFF_FFFF, 32'd4);
            chk("div_busy", 32'(b3), 32'h0);
        end

        // ---------------- reset wins over in_valid ----------------
        v0 = 1'b1; d0 = {9'h000, 9'h005};
        reset_n = 1'b0;
        tick();
        chk("rstwin_busy0", 32'(b0), 32'h0);
        chk("rstwin_step1", 32'(s1), 32'h0);
        v0 = 1'b0; d0 = '0;
        reset_n = 1'b1;
        tick();
        chk("rstwin_after", 32'(b0), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_trackball_quad
`default_nettype wire
